// File: rtl/pim_burst_reader.sv
// Read-only burst initiator for a single-port RAM: sweeps [base_addr, base_addr+length) and
// streams words through a 2-entry valid/ready buffer. Optional PIM_BURST_PARITY_EN adds out_parity.
`timescale 1ns/1ps
module pim_burst_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef PIM_BURST_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   sent;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    assign mem_we    = 1'b0;
    assign busy      = (state != IDLE);
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid && (sent == (ADDR_WIDTH+1)'(1));
    assign pop       = out_valid & out_ready;
    assign push      = inflight;

    // A read in flight already owns a buffer slot, so occupancy counts it; a same-cycle pop frees one.
    assign occ   = 3'(count) + 3'(inflight);
    assign issue = (state == RUN) && (remaining != '0) && (occ < 3'd2 + 3'(pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            done         <= 1'b0;
            mem_addr     <= '0;
            cur_addr     <= '0;
            remaining    <= '0;
            sent         <= '0;
            inflight     <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                mem_addr  <= cur_addr;
                cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH+1)'(1);
            end
            if (push) begin
                fifo_data[wr_ptr] <= mem_out;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                sent   <= sent - (ADDR_WIDTH+1)'(1);
            end
            count <= count + 2'(push) - 2'(pop);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            cur_addr  <= base_addr;
                            remaining <= length;
                            sent      <= length;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue && remaining == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIM_BURST_PARITY_EN
    logic fifo_par [2];

    assign out_parity = fifo_par[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_par[0] <= 1'b0;
            fifo_par[1] <= 1'b0;
        end else if (push) begin
            fifo_par[wr_ptr] <= ^mem_out;
        end
    end
`endif

endmodule

// File: tb/tb_pim_burst_reader.sv
// Directed bench for pim_burst_reader with a registered-address RAM model (RAM[i] = 0x1000+i).
`timescale 1ns/1ps
module tb_pim_burst_reader;
    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_we, out_valid, out_last;
    logic          out_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_out, out_data;
`ifdef PIM_BURST_PARITY_EN
    logic          out_parity;
`endif

    logic [DW-1:0] ram [0:1023];
    assign mem_out = ram[mem_addr];

    pim_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_out(mem_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef PIM_BURST_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit we_bad = 0;

    always @(negedge clk) if (mem_we !== 1'b0) we_bad = 1;

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    logic          got_par  [$];
    int            got_cyc  [$];
    logic [AW-1:0] got_addr [$];
    int            done_cyc, done_cnt, max_out;
    logic          busy_at_done, busy_first;

    // Starts a burst and records pops, issued addresses and done timing; cycle 0 = first negedge after the start edge.
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode, input int inject);
        logic [AW-1:0] prev;
        int issues, pops;
        got_data.delete(); got_last.delete(); got_par.delete(); got_cyc.delete(); got_addr.delete();
        done_cyc = -1; done_cnt = 0; max_out = 0; busy_at_done = 1'bx;
        @(negedge clk);
        prev = mem_addr;
        start = 1'b1; base_addr = b; length = l; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; base_addr = '0; length = '0;
        busy_first = busy;
        issues = 0; pops = 0;
        for (int k = 0; k < 300; k++) begin
            if (k == inject) begin
                start = 1'b1; base_addr = 10'd100; length = 11'd3;
            end else begin
                start = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            if (mem_addr !== prev) begin
                got_addr.push_back(mem_addr);
                issues++;
                prev = mem_addr;
            end
            if (issues - pops > max_out) max_out = issues - pops;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    busy_at_done = busy;
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 1) break;
            if (out_valid === 1'b1 && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_cyc.push_back(k);
`ifdef PIM_BURST_PARITY_EN
                got_par.push_back(out_parity);
`else
                got_par.push_back(^out_data);
`endif
                pops++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_stream(input string name, input logic [AW-1:0] b, input int n);
        logic [DW-1:0] exp;
        checks++;
        if (got_data.size() != n) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_data.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            exp = 16'h1000 + 16'(10'(b + 10'(i)));
            checks++;
            if (i >= got_data.size() || got_data[i] !== exp || got_last[i] !== (i == n - 1)) begin
                failures++;
                $display("FAIL %s_word[%0d] got=%h last=%b exp=%h last=%b", name, i,
                         (i < got_data.size()) ? got_data[i] : 16'hxxxx,
                         (i < got_last.size()) ? got_last[i] : 1'bx, exp, (i == n - 1));
            end
        end
        checks++;
        if (done_cnt != 1 || busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done got_pulses=%0d busy=%b exp_pulses=1 busy=0", name, done_cnt, busy_at_done);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (busy !== 0 || done !== 0 || mem_addr !== 0 || mem_we !== 0 || out_valid !== 0 ||
            out_last !== 0 || out_data !== 0) begin
            failures++;
            $display("FAIL reset_values got busy=%b done=%b addr=%h we=%b valid=%b last=%b data=%h exp all 0",
                     busy, done, mem_addr, mem_we, out_valid, out_last, out_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back;
        run_burst(10'd5, 11'd4, 0, -1);
        check_stream("b2b", 10'd5, 4);
        checks++;
        if (busy_first !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_rise got=%b exp=1", busy_first);
        end
        checks++;
        if (got_cyc.size() != 4 || got_cyc[0] != 2 || got_cyc[3] != 5 || done_cyc != 6) begin
            failures++;
            $display("FAIL b2b_timing got first=%0d last=%0d done=%0d exp 2 5 6",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, (got_cyc.size() > 3) ? got_cyc[3] : -1, done_cyc);
        end
        checks++;
        if (got_addr.size() != 4 || got_addr[0] !== 10'd5 || got_addr[3] !== 10'd8) begin
            failures++;
            $display("FAIL b2b_addrs got_n=%0d exp 4 addrs 5..8", got_addr.size());
        end
    endtask

    task automatic test_backpressure;
        run_burst(10'd5, 11'd4, 1, -1);
        check_stream("bp", 10'd5, 4);
        checks++;
        if (max_out != 2) begin
            failures++;
            $display("FAIL bp_occupancy got=%0d exp=2", max_out);
        end
        checks++;
        if (got_cyc.size() != 4 || got_cyc[0] != 3 || got_cyc[1] != 6 || got_cyc[3] != 12 || done_cyc != 13) begin
            failures++;
            $display("FAIL bp_timing got pop0=%0d pop1=%0d pop3=%0d done=%0d exp 3 6 12 13",
                     (got_cyc.size() > 0) ? got_cyc[0] : -1, (got_cyc.size() > 1) ? got_cyc[1] : -1,
                     (got_cyc.size() > 3) ? got_cyc[3] : -1, done_cyc);
        end
    endtask

    task automatic test_wrap;
        run_burst(10'd1022, 11'd4, 0, -1);
        check_stream("wrap", 10'd1022, 4);
        checks++;
        if (got_addr.size() != 4 || got_addr[0] !== 10'd1022 || got_addr[1] !== 10'd1023 ||
            got_addr[2] !== 10'd0 || got_addr[3] !== 10'd1) begin
            failures++;
            $display("FAIL wrap_addrs got_n=%0d first=%0d third=%0d exp 1022,1023,0,1", got_addr.size(),
                     (got_addr.size() > 0) ? got_addr[0] : 10'd0, (got_addr.size() > 2) ? got_addr[2] : 10'd0);
        end
    endtask

    task automatic test_zero_length;
        logic [AW-1:0] prev;
        @(negedge clk);
        prev = mem_addr;
        start = 1'b1; base_addr = 10'd40; length = '0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_addr !== prev) begin
            failures++;
            $display("FAIL zero_len_pulse got done=%b busy=%b addr=%h exp done=1 busy=0 addr=%h", done, busy, mem_addr, prev);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || mem_addr !== prev) begin
            failures++;
            $display("FAIL zero_len_after got done=%b busy=%b valid=%b addr=%h exp 0 0 0 %h", done, busy, out_valid, mem_addr, prev);
        end
    endtask

    task automatic test_start_while_busy;
        run_burst(10'd5, 11'd4, 0, 1);
        check_stream("busy_start", 10'd5, 4);
        checks++;
        if (got_addr.size() != 4 || done_cyc != 6) begin
            failures++;
            $display("FAIL busy_start_ignored got addrs=%0d done=%0d exp 4 6", got_addr.size(), done_cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_idle got busy=%b valid=%b exp 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_burst;
        int pops;
        bit reached;
        pops = 0; reached = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 10'd16; length = 11'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) pops++;
            if (pops == 2) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL mid_reset_wait got pops=%0d exp 2 within 20 cycles", pops);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 0 || busy !== 0 || done !== 0 || mem_addr !== 0 || out_data !== 0 || out_last !== 0) begin
            failures++;
            $display("FAIL mid_reset_async got valid=%b busy=%b done=%b addr=%h data=%h last=%b exp all 0",
                     out_valid, busy, done, mem_addr, out_data, out_last);
        end
        @(negedge clk);
        reset = 1'b0;
        reached = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) reached = 1;
        end
        checks++;
        if (reached) begin
            failures++;
            $display("FAIL mid_reset_quiet got activity after abort exp none");
        end
`ifdef PIM_BURST_PARITY_EN
        ram[0] = 16'h0007;
`endif
        run_burst(10'd0, 11'd2, 0, -1);
        checks++;
        if (got_data.size() != 2 || got_data[0] !== ram[0] || got_data[1] !== 16'h1001 ||
            got_last[1] !== 1'b1 || done_cyc != 4) begin
            failures++;
            $display("FAIL fresh_burst got n=%0d d0=%h d1=%h done=%0d exp n=2 d0=%h d1=1001 done=4", got_data.size(),
                     (got_data.size() > 0) ? got_data[0] : 16'hxxxx, (got_data.size() > 1) ? got_data[1] : 16'hxxxx,
                     done_cyc, ram[0]);
        end
`ifdef PIM_BURST_PARITY_EN
        checks++;
        if (got_par.size() != 2 || got_par[0] !== 1'b1 || got_par[1] !== 1'b0) begin
            failures++;
            $display("FAIL parity got n=%0d p0=%b p1=%b exp 1 0", got_par.size(),
                     (got_par.size() > 0) ? got_par[0] : 1'bx, (got_par.size() > 1) ? got_par[1] : 1'bx);
        end
        ram[0] = 16'h1000;
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'h1000 + 16'(i);
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_wrap;
        test_zero_length;
        test_start_while_busy;
        test_reset_mid_burst;
        checks++;
        if (we_bad) begin
            failures++;
            $display("FAIL mem_we got=1 at some point exp=0 throughout");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout exp completion before 200us");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pim_burst_reader.md
Name: pim_burst_reader

Overview:
- Read-side initiator for the memory_pim single-port RAM interface (data/addr/we/out, ADDR_WIDTH/DATA_WIDTH).
- On a start command, sweeps a contiguous address range and streams the read words out over a valid/ready interface with backpressure.
- Sits between a consumer (compute/checker logic) and the memory macro. It issues reads only and never writes.

Parameters:
- ADDR_WIDTH, 10, width of the memory address bus.
- DATA_WIDTH, 16, width of the memory data word.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- start  input  1  Command strobe; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  First address of the burst.
- length  input  ADDR_WIDTH+1  Word count, 0..2^ADDR_WIDTH.
- busy  output  1  High while a burst is in progress.
- done  output  1  One-cycle pulse when a burst completes.
- mem_addr  output  ADDR_WIDTH  Address to the RAM.
- mem_we  output  1  Write enable to the RAM; constant 0.
- mem_out  input  DATA_WIDTH  RAM read data; synchronous, valid 1 cycle after mem_addr.
- out_data  output  DATA_WIDTH  Streamed word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  Consumer accepts a word when valid & ready.
- out_last  output  1  Marks the final word of the burst; qualified by out_valid.

Behaviour:
- Reset values (asynchronous): state=IDLE, busy=0, done=0, mem_addr=0, mem_we=0, out_valid=0, out_last=0, out_data=0. FIFO is empty, in-flight flag is cleared, counters are 0.
- States:
  - IDLE: busy=0.
  - RUN: reads remain to issue.
  - DRAIN: all reads issued; waiting for the FIFO and in-flight read to empty.
- IDLE + start with length≠0:
  - Latch cur_addr=base_addr, remaining=length, sent=length, then go to RUN.
  - busy rises the next cycle.
- IDLE + start with length=0: done pulses the next cycle; state stays IDLE; no memory access.
- start outside IDLE is ignored.
- Output buffer: 2-entry FIFO.
  - out_valid = (count≠0).
  - out_data = head entry.
  - pop = out_valid & out_ready.
- Issue rule in RUN:
  - Issue when remaining>0 and (count + inflight − pop) < 2.
  - Issue means: mem_addr<=cur_addr, cur_addr<=cur_addr+1 (wraps modulo 2^ADDR_WIDTH), remaining<=remaining−1, inflight<=1.
  - Without an issue, inflight<=0 and mem_addr holds its value.
- Capture: in the cycle after an issue, mem_out is pushed into the FIFO. Push and pop in the same cycle are allowed, and count updates by push − pop.
- Throughput: with out_ready held high, one word per cycle.
  - First out_valid appears 2 cycles after the first issue: issue edge, then capture edge.
  - The first issue occurs in the first RUN cycle.
- Stall: out_ready=0 fills the FIFO to 2 and stops issue. No word is ever dropped or duplicated.
- out_last: asserted when the head word is the final word, i.e. sent counter==1. sent decrements on each pop.
- RUN → DRAIN when the final issue occurs.
- DRAIN → IDLE on the pop of the out_last word. done=1 for exactly the following cycle and busy=0 from that same cycle.
- Full range (length=2^ADDR_WIDTH) reads every address once, wrapping past the top.
- Reset mid-burst: aborts immediately. In-flight data and FIFO contents are discarded; no done pulse.

Optional Feature:
- Macro: PIM_BURST_PARITY_EN.
- Defined: adds output out_parity (1 bit) = XOR-reduction of out_data, registered alongside the FIFO entry and valid with out_valid; resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset asynchronously between edges → all outputs go to the listed reset values immediately, with mem_we=0 throughout.
- Back-to-back burst: preload RAM[i]=0x1000+i; start base=5, length=4, out_ready=1 → out_data 0x1005..0x1008 on 4 consecutive cycles; out_last only with 0x1008; done one cycle later; busy low from the done cycle.
- Backpressure: same burst with out_ready toggling 1,0,0,1,… → exact order 0x1005..0x1008; FIFO count never exceeds 2; no loss or duplicates; mem_addr issues stall while full.
- Wrap-around: base=1022, length=4, ADDR_WIDTH=10 → reads addresses 1022, 1023, 0, 1 in that order.
- Zero-length and start-while-busy:
  - length=0 → done pulse next cycle, busy stays 0, no new mem_addr.
  - A second start during RUN → ignored; the first burst completes unchanged.
- Reset mid-burst: assert reset after 2 words of a length-8 burst → out_valid=0 at once; no done; a fresh burst base=0, length=2 afterwards returns RAM[0], RAM[1] correctly. With PIM_BURST_PARITY_EN, data 0x0007 → out_parity=1.
